// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the per-cell decoders and alu_rr_scheduler.
// The master side is the requester/consumer; the slave side is the scheduler.
interface alu_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*5-1:0]      req_aluop;
  logic [NUM_REQ*IMM_W-1:0]  req_imm;
  logic [NUM_REQ*DATA_W-1:0] req_op_a;
  logic [NUM_REQ*DATA_W-1:0] req_op_b;
  logic [NUM_REQ*5-1:0]      req_prec;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_data;

  modport master (
    output req_valid, req_aluop, req_imm, req_op_a, req_op_b, req_prec, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_aluop, req_imm, req_op_a, req_op_b, req_prec, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU among NUM_REQ requesters via an issue/result pipeline.
// Define ALU_SCHED_PERF_EN to build the saturating perf_busy/perf_stall counters.
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 16,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_rr_scheduler_if.slave   bus,
  output logic [31:0]         perf_busy,
  output logic [31:0]         perf_stall
);

  typedef enum logic [4:0] {
    OP_LI    = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_NOR   = 5'd5,
    OP_SEQ   = 5'd6,
    OP_SLT   = 5'd7,
    OP_MUL   = 5'd8,
    OP_SHR   = 5'd9,
    OP_FMUL  = 5'd10,
    OP_FIX   = 5'd11,
    OP_UNFIX = 5'd12
  } aluop_e;

  // Unpacked per-requester views of the packed request fields
  logic [4:0]        aluop_arr [NUM_REQ];
  logic [IMM_W-1:0]  imm_arr   [NUM_REQ];
  logic [DATA_W-1:0] op_a_arr  [NUM_REQ];
  logic [DATA_W-1:0] op_b_arr  [NUM_REQ];
  logic [4:0]        prec_arr  [NUM_REQ];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      aluop_arr[i] = bus.req_aluop[i*5 +: 5];
      imm_arr[i]   = bus.req_imm[i*IMM_W +: IMM_W];
      op_a_arr[i]  = bus.req_op_a[i*DATA_W +: DATA_W];
      op_b_arr[i]  = bus.req_op_b[i*DATA_W +: DATA_W];
      prec_arr[i]  = bus.req_prec[i*5 +: 5];
    end
  end

  logic              i_valid;
  logic [ID_W-1:0]   i_id;
  logic [4:0]        i_aluop;
  logic [IMM_W-1:0]  i_imm;
  logic [DATA_W-1:0] i_op_a;
  logic [DATA_W-1:0] i_op_b;
  logic [4:0]        i_prec;

  logic              rsp_valid_q;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   grant;
  logic              found;
  int unsigned       scan_idx;
  logic              r_load;
  logic              accept_en;
  logic              handshake;
  logic [NUM_REQ-1:0] req_ready_c;

  assign r_load    = !rsp_valid_q || bus.rsp_ready;
  assign accept_en = !i_valid || r_load;

  // Scan ptr+1 .. ptr+NUM_REQ so the last winner has lowest priority
  always_comb begin
    found    = 1'b0;
    grant    = ptr;
    scan_idx = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (32'(ptr) + k) % 32'(NUM_REQ);
      if (!found && bus.req_valid[ID_W'(scan_idx)]) begin
        found = 1'b1;
        grant = ID_W'(scan_idx);
      end
    end
  end

  assign handshake = rst_n && accept_en && found;

  always_comb begin
    req_ready_c = '0;
    if (handshake) req_ready_c[grant] = 1'b1;
  end

  assign bus.req_ready = req_ready_c;

  // Shared ALU evaluated from the issue register
  logic signed [DATA_W-1:0]   sa;
  logic signed [DATA_W-1:0]   sb;
  logic signed [2*DATA_W-1:0] prod_full;
  logic [DATA_W-1:0]          diff;
  logic [DATA_W-1:0]          alu_res;

  always_comb begin
    sa        = i_op_a;
    sb        = i_op_b;
    prod_full = (2*DATA_W)'(sa) * (2*DATA_W)'(sb);
    diff      = i_op_a - i_op_b;
    alu_res   = '0;
    case (aluop_e'(i_aluop))
      OP_LI:    alu_res = DATA_W'(i_imm);
      OP_ADD:   alu_res = i_op_a + i_op_b;
      OP_SUB:   alu_res = diff;
      OP_AND:   alu_res = i_op_a & i_op_b;
      OP_OR:    alu_res = i_op_a | i_op_b;
      OP_NOR:   alu_res = ~(i_op_a | i_op_b);
      OP_SEQ:   alu_res = DATA_W'(i_op_a == i_op_b);
      OP_SLT:   alu_res = DATA_W'(diff[DATA_W-1]);
      OP_MUL:   alu_res = DATA_W'(prod_full);
      OP_SHR:   alu_res = sa >>> i_op_b;
      OP_FMUL:  alu_res = DATA_W'(prod_full >>> i_prec);
      OP_FIX:   alu_res = i_op_b << i_prec;
      OP_UNFIX: alu_res = sb >>> i_prec;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_valid     <= 1'b0;
      i_id        <= '0;
      i_aluop     <= '0;
      i_imm       <= '0;
      i_op_a      <= '0;
      i_op_b      <= '0;
      i_prec      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      ptr         <= ID_W'(NUM_REQ - 1);
    end else begin
      if (r_load) begin
        rsp_valid_q <= i_valid;
        if (i_valid) begin
          rsp_id_q   <= i_id;
          rsp_data_q <= alu_res;
        end
      end
      if (accept_en) begin
        i_valid <= handshake;
        if (handshake) begin
          i_id    <= grant;
          i_aluop <= aluop_arr[grant];
          i_imm   <= imm_arr[grant];
          i_op_a  <= op_a_arr[grant];
          i_op_b  <= op_b_arr[grant];
          i_prec  <= prec_arr[grant];
          ptr     <= grant;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] busy_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      if (i_valid && (busy_q != '1)) busy_q <= busy_q + 32'd1;
      if (rsp_valid_q && !bus.rsp_ready && (stall_q != '1)) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_busy  = busy_q;
  assign perf_stall = stall_q;
`else
  assign perf_busy  = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: arbitration order, latency, backpressure, ALU ops, reset.
module tb_alu_rr_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int IMM_W   = 16;
  localparam int ID_W    = 2;

  localparam logic [4:0] LI = 5'd0, ADD = 5'd1, SUB = 5'd2, AND_ = 5'd3, OR_ = 5'd4,
                         NOR_ = 5'd5, SEQ = 5'd6, SLT = 5'd7, MUL = 5'd8, SHR = 5'd9,
                         FMUL = 5'd10, FIX = 5'd11, UNFIX = 5'd12, BAD = 5'd31;

  logic        clk;
  logic        rst_n;
  logic [31:0] perf_busy;
  logic [31:0] perf_stall;
  int          total;
  int          bad;

  alu_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IMM_W(IMM_W), .ID_W(ID_W)) bus ();

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IMM_W(IMM_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .perf_busy  (perf_busy),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic v, input logic [4:0] op, input logic [15:0] imm,
                         input logic [15:0] a, input logic [15:0] b, input logic [4:0] prec);
    bus.req_valid[idx]            = v;
    bus.req_aluop[idx*5 +: 5]     = op;
    bus.req_imm[idx*IMM_W +: IMM_W]   = imm;
    bus.req_op_a[idx*DATA_W +: DATA_W] = a;
    bus.req_op_b[idx*DATA_W +: DATA_W] = b;
    bus.req_prec[idx*5 +: 5]      = prec;
  endtask

  task automatic clear_inputs;
    bus.req_valid = '0;
    bus.req_aluop = '0;
    bus.req_imm   = '0;
    bus.req_op_a  = '0;
    bus.req_op_b  = '0;
    bus.req_prec  = '0;
    bus.rsp_ready = 1'b1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // One isolated operation: handshake, two cycles later check the response
  task automatic run_op(input string tag, input int idx, input logic [4:0] op, input logic [15:0] imm,
                        input logic [15:0] a, input logic [15:0] b, input logic [4:0] prec,
                        input logic [15:0] exp);
    set_req(idx, 1'b1, op, imm, a, b, prec);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << idx);
    tick();
    set_req(idx, 1'b0, '0, '0, '0, '0, '0);
    tick();
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(idx));
    check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    clear_inputs();

    // Reset state, with a request already asserted during reset
    set_req(2, 1'b1, ADD, 16'd0, 16'd5, 16'd7, 5'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_data", 32'(bus.rsp_data), 32'd0);
    check("rst_busy", perf_busy, 32'd0);
    check("rst_stall", perf_stall, 32'd0);

    // 1: single request from requester 2, latency of two cycles
    rst_n = 1'b1;
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, '0, '0, '0, '0, '0);
    #1;
    check("t1_valid_n1", 32'(bus.rsp_valid), 32'd0);
    tick();
    check("t1_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_id", 32'(bus.rsp_id), 32'd2);
    check("t1_data", 32'(bus.rsp_data), 32'd12);
    tick();
    check("t1_valid_after", 32'(bus.rsp_valid), 32'd0);

    // 2: all requesters continuously valid, round-robin 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, MUL, 16'd0, 16'(i + 1), 16'd3, 5'd0);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_grant", 32'(bus.req_ready), 32'(1) << (k % 4));
      if (k >= 2) begin
        check("t2_valid", 32'(bus.rsp_valid), 32'd1);
        check("t2_id", 32'(bus.rsp_id), 32'((k - 2) % 4));
        check("t2_data", 32'(bus.rsp_data), 32'(3 * ((k - 2) % 4 + 1)));
      end
      tick();
    end
    clear_inputs();
    #1;
    check("t2_ready_idle", 32'(bus.req_ready), 32'd0);
    check("t2_id6", 32'(bus.rsp_id), 32'd2);
    check("t2_data6", 32'(bus.rsp_data), 32'd9);
    tick();
    check("t2_id7", 32'(bus.rsp_id), 32'd3);
    check("t2_data7", 32'(bus.rsp_data), 32'd12);
    tick();
    check("t2_drained", 32'(bus.rsp_valid), 32'd0);

    // 3: backpressure for five cycles with three pending requests
    do_reset();
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, ADD, 16'd0, 16'(i), 16'd100, 5'd0);
    #1;
    check("t3_acc0", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, '0, '0, '0, '0, '0);
    #1;
    check("t3_acc1", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, '0, '0, '0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_stall_ready", 32'(bus.req_ready), 32'd0);
      check("t3_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("t3_hold_id", 32'(bus.rsp_id), 32'd0);
      check("t3_hold_data", 32'(bus.rsp_data), 32'd100);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("t3_acc2", 32'(bus.req_ready), 32'h4);
    tick();
    set_req(2, 1'b0, '0, '0, '0, '0, '0);
    check("t3_r1_id", 32'(bus.rsp_id), 32'd1);
    check("t3_r1_data", 32'(bus.rsp_data), 32'd101);
    tick();
    check("t3_r2_valid", 32'(bus.rsp_valid), 32'd1);
    check("t3_r2_id", 32'(bus.rsp_id), 32'd2);
    check("t3_r2_data", 32'(bus.rsp_data), 32'd102);
    tick();
    check("t3_drained", 32'(bus.rsp_valid), 32'd0);
`ifdef ALU_SCHED_PERF_EN
    check("t3_perf_stall", perf_stall, 32'd5);
    check("t3_perf_busy", perf_busy, 32'd8);
`else
    check("t3_perf_stall", perf_stall, 32'd0);
    check("t3_perf_busy", perf_busy, 32'd0);
`endif

    // 4: ALU function table
    run_op("fmul",  1, FMUL,  16'd0,      16'h0180, 16'h0200, 5'd8, 16'h0300);
    run_op("unfix", 3, UNFIX, 16'd0,      16'h0000, 16'hFF00, 5'd4, 16'hFFF0);
    run_op("li",    0, LI,    16'h1234,   16'h0000, 16'h0000, 5'd0, 16'h1234);
    run_op("sub",   2, SUB,   16'd0,      16'd3,    16'd5,    5'd0, 16'hFFFE);
    run_op("and",   1, AND_,  16'd0,      16'hF0F0, 16'h0FF0, 5'd0, 16'h00F0);
    run_op("or",    1, OR_,   16'd0,      16'hF0F0, 16'h0FF0, 5'd0, 16'hFFF0);
    run_op("nor",   1, NOR_,  16'd0,      16'hF0F0, 16'h0FF0, 5'd0, 16'h000F);
    run_op("seq",   0, SEQ,   16'd0,      16'd7,    16'd7,    5'd0, 16'h0001);
    run_op("slt",   3, SLT,   16'd0,      16'hFFFE, 16'd1,    5'd0, 16'h0001);
    run_op("mul",   2, MUL,   16'd0,      16'h0100, 16'h0100, 5'd0, 16'h0000);
    run_op("shr",   0, SHR,   16'd0,      16'h8000, 16'd4,    5'd0, 16'hF800);
    run_op("fix",   1, FIX,   16'd0,      16'd0,    16'd3,    5'd4, 16'h0030);
    run_op("undef", 2, BAD,   16'hFFFF,   16'h1234, 16'h5678, 5'd3, 16'h0000);

    // 5: asynchronous reset with both stages full
    do_reset();
    bus.rsp_ready = 1'b0;
    set_req(1, 1'b1, ADD, 16'd0, 16'd1, 16'd1, 5'd0);
    set_req(2, 1'b1, ADD, 16'd0, 16'd2, 16'd2, 5'd0);
    tick();
    tick();
    check("t5_full_valid", 32'(bus.rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus.rsp_valid), 32'd0);
    check("t5_async_data", 32'(bus.rsp_data), 32'd0);
    check("t5_async_ready", 32'(bus.req_ready), 32'd0);
    clear_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    set_req(0, 1'b1, ADD, 16'd0, 16'd10, 16'd20, 5'd0);
    set_req(3, 1'b1, ADD, 16'd0, 16'd30, 16'd40, 5'd0);
    #1;
    check("t5_first_grant", 32'(bus.req_ready), 32'h1);
    check("t5_no_stale0", 32'(bus.rsp_valid), 32'd0);
    tick();
    set_req(0, 1'b0, '0, '0, '0, '0, '0);
    #1;
    check("t5_second_grant", 32'(bus.req_ready), 32'h8);
    check("t5_no_stale1", 32'(bus.rsp_valid), 32'd0);
    tick();
    set_req(3, 1'b0, '0, '0, '0, '0, '0);
    check("t5_r0_id", 32'(bus.rsp_id), 32'd0);
    check("t5_r0_data", 32'(bus.rsp_data), 32'd30);
    tick();
    check("t5_r3_id", 32'(bus.rsp_id), 32'd3);
    check("t5_r3_data", 32'(bus.rsp_data), 32'd70);
    tick();
    check("t5_drained", 32'(bus.rsp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
